// File: rtl/ov7670_fifo_reader.sv
// OV7670 + AL422 FIFO frame grabber: arms on VSYNC, lets the camera write one
// frame into the FIFO, resets the read pointer, then streams the frame out a
// byte at a time over a valid/ready interface with a generated read clock.
module ov7670_fifo_reader #(
  parameter int FRAME_BYTES = 614400,
  parameter int RCLK_HALF   = 4,
  parameter int WRST_CYCLES = 100,
  parameter int RRST_PULSES = 2
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       start,
  input  logic       cam_vsync,
  input  logic [7:0] cam_data,
  output logic       cam_wrst_n,
  output logic       cam_we,
  output logic       cam_rrst_n,
  output logic       cam_rclk,
  output logic       cam_oe_n,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int BYTE_W  = $clog2(FRAME_BYTES + 1);
  localparam int CNT_MAX = (WRST_CYCLES > RCLK_HALF) ? WRST_CYCLES : RCLK_HALF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PULSE_W = $clog2(RRST_PULSES + 1);

  localparam logic [CNT_W-1:0]   WRST_LAST  = CNT_W'(WRST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(RCLK_HALF - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RRST_PULSES - 1);
  localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [BYTE_W-1:0]  BYTE_TOTAL = BYTE_W'(FRAME_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WRST, S_WRITE, S_RRST, S_READ, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               vs_meta_q, vs_meta_d;
  logic               vs_sync_q, vs_sync_d;
  logic               vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic               rclk_q, rclk_d;
  logic               pending_q, pending_d;
  logic [BYTE_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic vs_rise;
  logic transfer;
  logic load_ok;

  assign vs_rise  = vs_sync_q & ~vs_prev_q;
  assign transfer = out_valid_q & out_ready;

  // Next-state, synchronizer chain and read-clock / output-register sequencing
  always_comb begin
    state_d     = state_q;
    vs_meta_d   = cam_vsync;
    vs_sync_d   = vs_meta_q;
    vs_prev_d   = vs_sync_q;
    cnt_d       = cnt_q;
    pulse_d     = pulse_q;
    rclk_d      = rclk_q;
    pending_d   = pending_q;
    rd_cnt_d    = rd_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    load_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ARM;
          cnt_d       = '0;
          pulse_d     = '0;
          rclk_d      = 1'b0;
          pending_d   = 1'b0;
          rd_cnt_d    = '0;
          byte_cnt_d  = '0;
          out_valid_d = 1'b0;
        end
      end

      S_ARM: begin
        if (vs_rise) begin
          state_d = S_WRST;
          cnt_d   = '0;
        end
      end

      S_WRST: begin
        // vs_rise is deliberately not looked at here
        if (cnt_q == WRST_LAST) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WRITE: begin
        if (vs_rise) begin
          state_d = S_RRST;
          cnt_d   = '0;
          pulse_d = '0;
          rclk_d  = 1'b0;
        end
      end

      S_RRST: begin
        // Low half first, then high; leave on the last falling edge
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          rclk_d = ~rclk_q;
          if (rclk_q) begin
            if (pulse_q == PULSE_LAST) begin
              state_d = S_READ;
              pulse_d = '0;
            end else begin
              pulse_d = pulse_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_READ: begin
        if (transfer) begin
          out_valid_d = 1'b0;
          byte_cnt_d  = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BYTE_LAST) begin
            state_d = S_DONE;
          end
        end
        if (rclk_q) begin
          if (cnt_q == HALF_LAST) begin
            rclk_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // End of the low phase: FIFO data is settled. Capture only when the
          // output register is free (empty, or emptied this clock); otherwise
          // hold rclk low so the FIFO keeps presenting the same byte.
          load_ok = pending_q & (~out_valid_q | out_ready);
          if (load_ok) begin
            out_data_d  = cam_data;
            out_valid_d = 1'b1;
            pending_d   = 1'b0;
          end
          if ((rd_cnt_q != BYTE_TOTAL) && (~pending_q | load_ok)) begin
            rclk_d    = 1'b1;
            cnt_d     = '0;
            rd_cnt_d  = rd_cnt_q + 1'b1;
            pending_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        rd_cnt_d   = '0;
        byte_cnt_d = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vs_meta_q   <= 1'b0;
      vs_sync_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      pulse_q     <= '0;
      rclk_q      <= 1'b0;
      pending_q   <= 1'b0;
      rd_cnt_q    <= '0;
      byte_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_meta_q   <= vs_meta_d;
      vs_sync_q   <= vs_sync_d;
      vs_prev_q   <= vs_prev_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      rclk_q      <= rclk_d;
      pending_q   <= pending_d;
      rd_cnt_q    <= rd_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cam_wrst_n = (state_q != S_WRST);
  assign cam_we     = (state_q == S_WRST) || (state_q == S_WRITE);
  assign cam_rrst_n = (state_q != S_RRST);
  assign cam_rclk   = rclk_q;
  assign cam_oe_n   = (state_q != S_READ);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ov7670_fifo_reader.sv
// Bench for ov7670_fifo_reader with a small AL422 read-side model: the FIFO
// holds a byte array, the read pointer clears on an rclk rise while
// cam_rrst_n is low, and each other rclk rise presents the next byte.
module tb_ov7670_fifo_reader;

  localparam int FB = 16;
  localparam int RH = 4;
  localparam int WC = 100;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       cam_wrst_n, cam_we, cam_rrst_n, cam_rclk, cam_oe_n;
  logic [7:0] out_data;
  logic       out_valid, busy, frame_done;

  always #5 clk = ~clk;

  ov7670_fifo_reader #(
    .FRAME_BYTES(FB), .RCLK_HALF(RH), .WRST_CYCLES(WC), .RRST_PULSES(RP)
  ) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .start(start), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .cam_wrst_n(cam_wrst_n), .cam_we(cam_we),
    .cam_rrst_n(cam_rrst_n), .cam_rclk(cam_rclk), .cam_oe_n(cam_oe_n),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done)
  );

  // AL422 read port model
  logic [7:0] mem [0:FB-1];
  int cam_ptr = 0;
  always @(posedge cam_rclk) begin
    if (!cam_rrst_n) begin
      cam_ptr <= 0;
    end else begin
      #2;
      cam_data <= mem[cam_ptr % FB];
      cam_ptr  <= cam_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  // Per-frame observations filled by do_frame
  logic [7:0] got[$];
  int wrst_low, we_bad, rrst_rises, read_rises, period_bad, done_cycles;
  int post_busy, stall_viol, we_at_rrst, rclk_at_rrst_end;
  bit in_write_ok, timed_out, stall_seen;

  task automatic fill_random();
    for (int i = 0; i < FB; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // ready_mode: 0 always ready, 1 one 50-clock stall mid-read, 2 random
  task automatic do_frame(input int ready_mode, input bit start_in_read,
                          input bit vs_in_wrst, input bit abort_read);
    int  prev_rclk, prev_rrst, last_rise, stall_left, stall_cyc;
    logic [7:0] stall_data;
    bit  busy_seen, finished, rise;
    got.delete();
    wrst_low = 0; we_bad = 0; rrst_rises = 0; read_rises = 0; period_bad = 0;
    done_cycles = 0; post_busy = 0; stall_viol = 0; we_at_rrst = -1;
    rclk_at_rrst_end = -1; in_write_ok = 0; timed_out = 0; stall_seen = 0;
    prev_rclk = 0; prev_rrst = 1; last_rise = -1; stall_left = 0;
    stall_data = 8'h00; busy_seen = 0; finished = 0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (abort_read && read_rises >= 5) return;
      start = (c == 0) || (start_in_read && !cam_oe_n && read_rises >= 3 && read_rises <= 4);
      cam_vsync = (c >= 5 && c < 10) || (vs_in_wrst && c >= 40 && c < 45) ||
                  (c >= 160 && c < 165);
      if (ready_mode == 1 && !stall_seen && read_rises >= 6 && out_valid) begin
        stall_seen = 1;
        stall_left = 50;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (stall_left == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (c == 158) in_write_ok = cam_we && cam_wrst_n && cam_rrst_n && busy;
      if (!cam_wrst_n) begin
        wrst_low++;
        if (!cam_we) we_bad++;
      end
      rise = cam_rclk && (prev_rclk == 0);
      if (rise && !cam_rrst_n) rrst_rises++;
      if (rise && !cam_oe_n) begin
        read_rises++;
        if (ready_mode == 0 && last_rise >= 0 && (c - last_rise) != 2 * RH) period_bad++;
        last_rise = c;
      end
      if (!cam_rrst_n && we_at_rrst < 0) we_at_rrst = int'(cam_we);
      if (cam_rrst_n && prev_rrst == 0) rclk_at_rrst_end = int'(cam_rclk);
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) done_cycles++;
      if (stall_left > 0) begin
        stall_cyc = 50 - stall_left;
        if (stall_cyc == 10) stall_data = out_data;
        if (stall_cyc >= 10 && (!out_valid || out_data !== stall_data || cam_rclk || rise))
          stall_viol++;
        stall_left--;
      end
      if (busy) busy_seen = 1;
      else if (busy_seen) finished = 1;
      prev_rclk = int'(cam_rclk);
      prev_rrst = int'(cam_rrst_n);
    end
    timed_out = !finished;
    start = 1'b0;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      cam_vsync = (p >= 3 && p < 8);
      out_ready = 1'b1;
      if (busy) post_busy++;
      if (frame_done) done_cycles++;
    end
    cam_vsync = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    @(negedge clk);
    checks++; if (cam_wrst_n !== 1'b1) begin errors++; $display("FAIL reset_wrst_n: got %b want 1", cam_wrst_n); end
    checks++; if (cam_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", cam_we); end
    checks++; if (cam_rrst_n !== 1'b1) begin errors++; $display("FAIL reset_rrst_n: got %b want 1", cam_rrst_n); end
    checks++; if (cam_rclk !== 1'b0) begin errors++; $display("FAIL reset_rclk: got %b want 0", cam_rclk); end
    checks++; if (cam_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", cam_oe_n); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cam_vsync = ((i % 8) < 4);
      if (busy !== 1'b0 || cam_we !== 1'b0 || cam_wrst_n !== 1'b1 || cam_rrst_n !== 1'b1 ||
          cam_rclk !== 1'b0 || cam_oe_n !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0)
        bad++;
    end
    cam_vsync = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_vsync_no_start: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_write_phase();
    fill_random();
    do_frame(0, 0, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL write_timeout: frame did not finish"); end
    checks++; if (wrst_low !== WC) begin errors++; $display("FAIL wrst_len: got %0d want %0d", wrst_low, WC); end
    checks++; if (we_bad !== 0) begin errors++; $display("FAIL we_in_wrst: %0d low cycles want 0", we_bad); end
    checks++; if (we_at_rrst !== 0) begin errors++; $display("FAIL we_after_vsync: got %0d want 0", we_at_rrst); end
    checks++; if (rrst_rises !== RP) begin errors++; $display("FAIL rrst_rclk_periods: got %0d want %0d", rrst_rises, RP); end
    checks++; if (rclk_at_rrst_end !== 0) begin errors++; $display("FAIL rclk_at_rrst_release: got %0d want 0", rclk_at_rrst_end); end
  endtask

  task automatic test_frame_incr();
    for (int i = 0; i < FB; i++) mem[i] = 8'(i);
    do_frame(0, 0, 0, 0);
    checks++; if (got.size() !== FB) begin errors++; $display("FAIL incr_count: got %0d want %0d", got.size(), FB); end
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'(i)) begin
        errors++;
        $display("FAIL incr_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(i));
      end
    end
    checks++; if (read_rises !== FB) begin errors++; $display("FAIL incr_rclk_edges: got %0d want %0d", read_rises, FB); end
    checks++; if (period_bad !== 0) begin errors++; $display("FAIL incr_rclk_period: %0d periods not %0d clocks", period_bad, 2 * RH); end
    checks++; if (done_cycles !== 1) begin errors++; $display("FAIL incr_frame_done: got %0d cycles want 1", done_cycles); end
    checks++; if (post_busy !== 0) begin errors++; $display("FAIL incr_busy_after: got %0d busy cycles want 0", post_busy); end
  endtask

  task automatic test_stall();
    fill_random();
    do_frame(1, 0, 0, 0);
    checks++; if (!stall_seen) begin errors++; $display("FAIL stall_entered: got 0 want 1"); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles want 0", stall_viol); end
    checks++; if (read_rises !== FB) begin errors++; $display("FAIL stall_rclk_edges: got %0d want %0d", read_rises, FB); end
    checks++; if (got.size() !== FB) begin errors++; $display("FAIL stall_count: got %0d want %0d", got.size(), FB); end
    for (int i = 0; i < FB && i < got.size(); i++) begin
      checks++;
      if (got[i] !== mem[i]) begin errors++; $display("FAIL stall_byte[%0d]: got %h want %h", i, got[i], mem[i]); end
    end
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 2; r++) begin
      fill_random();
      do_frame(2, 0, 0, 0);
      checks++; if (got.size() !== FB) begin errors++; $display("FAIL rand_count: got %0d want %0d", got.size(), FB); end
      for (int i = 0; i < FB && i < got.size(); i++) begin
        checks++;
        if (got[i] !== mem[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got[i], mem[i]); end
      end
      checks++; if (done_cycles !== 1) begin errors++; $display("FAIL rand_frame_done: got %0d want 1", done_cycles); end
    end
  endtask

  task automatic test_ignore();
    fill_random();
    do_frame(0, 1, 1, 0);
    checks++; if (wrst_low !== WC) begin errors++; $display("FAIL ign_wrst_len: got %0d want %0d", wrst_low, WC); end
    checks++; if (!in_write_ok) begin errors++; $display("FAIL ign_still_writing: got 0 want 1"); end
    checks++; if (got.size() !== FB) begin errors++; $display("FAIL ign_count: got %0d want %0d", got.size(), FB); end
    for (int i = 0; i < FB && i < got.size(); i++) begin
      checks++;
      if (got[i] !== mem[i]) begin errors++; $display("FAIL ign_byte[%0d]: got %h want %h", i, got[i], mem[i]); end
    end
    checks++; if (done_cycles !== 1) begin errors++; $display("FAIL ign_frame_done: got %0d want 1", done_cycles); end
    checks++; if (post_busy !== 0) begin errors++; $display("FAIL ign_busy_after: got %0d want 0", post_busy); end
  endtask

  task automatic test_reset_mid_read();
    int dn, bz;
    fill_random();
    do_frame(0, 0, 0, 1);
    checks++; if (cam_oe_n !== 1'b0) begin errors++; $display("FAIL abort_in_read: oe_n got %b want 0", cam_oe_n); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (cam_oe_n !== 1'b1) begin errors++; $display("FAIL abort_oe_n: got %b want 1", cam_oe_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL abort_out_data: got %h want 00", out_data); end
    checks++; if (cam_rclk !== 1'b0) begin errors++; $display("FAIL abort_rclk: got %b want 0", cam_rclk); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_frame_done: got %b want 0", frame_done); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dn = 0; bz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cam_vsync = (i >= 5 && i < 10);
      if (frame_done) dn++;
      if (busy) bz++;
    end
    cam_vsync = 1'b0;
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    checks++; if (bz !== 0) begin errors++; $display("FAIL abort_needs_start: got %0d busy cycles want 0", bz); end
    fill_random();
    do_frame(0, 0, 0, 0);
    checks++; if (got.size() !== FB) begin errors++; $display("FAIL after_abort_count: got %0d want %0d", got.size(), FB); end
    for (int i = 0; i < FB && i < got.size(); i++) begin
      checks++;
      if (got[i] !== mem[i]) begin errors++; $display("FAIL after_abort_byte[%0d]: got %h want %h", i, got[i], mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < FB; i++) mem[i] = 8'h00;
    test_reset();
    test_write_phase();
    test_frame_incr();
    test_stall();
    test_random_ready();
    test_ignore();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
